// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR address map, fcsr field layout and pending-write packet
package csr_pkg;
    localparam int CSR_W      = 64;
    localparam int CSR_ADDR_W = 12;
    localparam int COMMIT_W   = 4;
    localparam int CNT_INC_W  = 3;
    localparam int FFLAGS_W   = 5;
    localparam int FRM_W      = 3;
    localparam int FFLAGS_LSB = 0;
    localparam int FRM_LSB    = FFLAGS_LSB + FFLAGS_W;

    localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS   = 12'h001;
    localparam logic [CSR_ADDR_W-1:0] CSR_FRM      = 12'h002;
    localparam logic [CSR_ADDR_W-1:0] CSR_FCSR     = 12'h003;
    localparam logic [CSR_ADDR_W-1:0] CSR_SCRATCH  = 12'h140;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
    localparam logic [CSR_ADDR_W-1:0] CSR_TIME     = 12'hC01;
    localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET  = 12'hC02;
    localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [CSR_ADDR_W-1:0] CSR_TIMEH    = 12'hC81;
    localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH = 12'hC82;

    typedef struct packed {
        logic                  valid;
        logic [CSR_ADDR_W-1:0] addr;
        logic [CSR_W-1:0]      data;
    } csr_pending_pkt;
endpackage

// File: rtl/csr_counter.sv
// csr_counter: wrap-around accumulator with a narrow per-cycle increment
module csr_counter
    import csr_pkg::*;
#(
    parameter int W     = CSR_W,
    parameter int INC_W = CNT_INC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);
    always_ff @(posedge clk)
        count <= reset ? '0 : count + W'(inc);
endmodule

// File: rtl/csr_file.sv
// csr_file: architectural CSRs with a one-entry speculative write buffer applied at commit
// Optional CSR_SCRATCH_EN adds a read/write scratch register at 0x140.
module csr_file
    import csr_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CSR_ADDR_W-1:0] csrRdAddr_i,
    output logic [CSR_W-1:0]      csrRdData_o,
    output logic                  csrRdIllegal_o,
    input  logic                  exeCsrWrEn_i,
    input  logic [CSR_ADDR_W-1:0] exeCsrWrAddr_i,
    input  logic [CSR_W-1:0]      exeCsrWrData_i,
    output logic                  csrBusy_o,
    input  logic                  commitCsr_i,
    input  logic                  recoverFlag_i,
    input  logic [CNT_INC_W-1:0]  commitCnt_i,
    input  logic                  fpFlagsValid_i,
    input  logic [FFLAGS_W-1:0]   fpFlags_i,
    output logic [FRM_W-1:0]      frm_o
);
    csr_pending_pkt      pend;
    logic [FFLAGS_W-1:0] fflags;
    logic [FRM_W-1:0]    frm;
    logic [CSR_W-1:0]    cycle;
    logic [CSR_W-1:0]    instret;
    logic                wr;
    logic                wr_fflags;
    logic                wr_frm;
    logic                wr_fcsr;

    csr_counter u_cycle (
        .clk   (clk),
        .reset (reset),
        .inc   (CNT_INC_W'(1)),
        .count (cycle)
    );

    csr_counter u_instret (
        .clk   (clk),
        .reset (reset),
        .inc   (commitCnt_i),
        .count (instret)
    );

    assign wr        = commitCsr_i && pend.valid;
    assign wr_fflags = wr && (pend.addr == CSR_FFLAGS);
    assign wr_frm    = wr && (pend.addr == CSR_FRM);
    assign wr_fcsr   = wr && (pend.addr == CSR_FCSR);
    assign csrBusy_o = pend.valid;
    assign frm_o     = frm;

`ifdef CSR_SCRATCH_EN
    logic [CSR_W-1:0] scratch;

    always_ff @(posedge clk)
        scratch <= reset ? '0 : (wr && pend.addr == CSR_SCRATCH) ? pend.data : scratch;
`else
    logic unused_data;

    assign unused_data = ^pend.data[CSR_W-1:FRM_LSB+FRM_W];
`endif

    // Reads see only architectural state; the pending write is never forwarded
    always_comb begin
        csrRdData_o    = '0;
        csrRdIllegal_o = 1'b0;
        case (csrRdAddr_i)
            CSR_FFLAGS:                                   csrRdData_o = CSR_W'(fflags);
            CSR_FRM:                                      csrRdData_o = CSR_W'(frm);
            CSR_FCSR:                                     csrRdData_o = CSR_W'({frm, fflags});
            CSR_CYCLE, CSR_TIME, CSR_CYCLEH, CSR_TIMEH:   csrRdData_o = cycle;
            CSR_INSTRET, CSR_INSTRETH:                    csrRdData_o = instret;
`ifdef CSR_SCRATCH_EN
            CSR_SCRATCH:                                  csrRdData_o = scratch;
`endif
            default:                                      csrRdIllegal_o = 1'b1;
        endcase
    end

    // A committed fflags/fcsr write overrides same-cycle flag accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= '0;
            fflags <= '0;
            frm    <= '0;
        end else begin
            if (recoverFlag_i || wr)
                pend.valid <= 1'b0;
            else if (exeCsrWrEn_i && !pend.valid)
                pend <= '{valid: 1'b1, addr: exeCsrWrAddr_i, data: exeCsrWrData_i};
            fflags <= (wr_fflags || wr_fcsr) ? pend.data[FFLAGS_LSB+:FFLAGS_W]
                    : fpFlagsValid_i ? (fflags | fpFlags_i) : fflags;
            frm    <= wr_frm ? pend.data[FRM_W-1:0] : wr_fcsr ? pend.data[FRM_LSB+:FRM_W] : frm;
        end
    end

    a_wr_while_busy: assert property (@(posedge clk) disable iff (reset)
        !(exeCsrWrEn_i && pend.valid && !recoverFlag_i));
    a_commit_no_pend: assert property (@(posedge clk) disable iff (reset)
        !(commitCsr_i && !pend.valid));
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboard bench for csr_file (honours CSR_SCRATCH_EN)
module tb_csr_file;
    import csr_pkg::*;

    typedef struct packed {
        logic             ill;
        logic [CSR_W-1:0] data;
    } rd_exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [CSR_ADDR_W-1:0] csrRdAddr_i = '0;
    logic [CSR_W-1:0]      csrRdData_o;
    logic                  csrRdIllegal_o;
    logic                  exeCsrWrEn_i = 1'b0;
    logic [CSR_ADDR_W-1:0] exeCsrWrAddr_i = '0;
    logic [CSR_W-1:0]      exeCsrWrData_i = '0;
    logic                  csrBusy_o;
    logic                  commitCsr_i = 1'b0;
    logic                  recoverFlag_i = 1'b0;
    logic [CNT_INC_W-1:0]  commitCnt_i = '0;
    logic                  fpFlagsValid_i = 1'b0;
    logic [FFLAGS_W-1:0]   fpFlags_i = '0;
    logic [FRM_W-1:0]      frm_o;

    int         n_tests = 0;
    int         n_fail = 0;
    rd_exp_t    sb[$];
    logic [63:0] cyc_m = '0;

    csr_file dut (
        .clk            (clk),
        .reset          (reset),
        .csrRdAddr_i    (csrRdAddr_i),
        .csrRdData_o    (csrRdData_o),
        .csrRdIllegal_o (csrRdIllegal_o),
        .exeCsrWrEn_i   (exeCsrWrEn_i),
        .exeCsrWrAddr_i (exeCsrWrAddr_i),
        .exeCsrWrData_i (exeCsrWrData_i),
        .csrBusy_o      (csrBusy_o),
        .commitCsr_i    (commitCsr_i),
        .recoverFlag_i  (recoverFlag_i),
        .commitCnt_i    (commitCnt_i),
        .fpFlagsValid_i (fpFlagsValid_i),
        .fpFlags_i      (fpFlags_i),
        .frm_o          (frm_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk)
        cyc_m <= reset ? 64'd0 : cyc_m + 64'd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [CSR_ADDR_W-1:0] a,
                      input logic [63:0] exp, input logic exp_ill);
        rd_exp_t e;
        csrRdAddr_i = a;
        sb.push_back('{ill: exp_ill, data: exp});
        #1;
        e = sb.pop_front();
        check({tag, "_data"}, csrRdData_o, e.data);
        check({tag, "_ill"}, 64'(csrRdIllegal_o), 64'(e.ill));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic capture(input logic [CSR_ADDR_W-1:0] a, input logic [63:0] d);
        exeCsrWrEn_i   = 1'b1;
        exeCsrWrAddr_i = a;
        exeCsrWrData_i = d;
        cyc();
        exeCsrWrEn_i = 1'b0;
    endtask

    task automatic wr_commit(input logic [CSR_ADDR_W-1:0] a, input logic [63:0] d);
        capture(a, d);
        commitCsr_i = 1'b1;
        cyc();
        commitCsr_i = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_busy", 64'(csrBusy_o), 64'd0);
        check("rst_frm", 64'(frm_o), 64'd0);
        rd("rst_fcsr", CSR_FCSR, 64'd0, 1'b0);
        rd("rst_cycle", CSR_CYCLE, 64'd0, 1'b0);
        reset = 1'b0;
        repeat (10) cyc();
        rd("idle_cycle", CSR_CYCLE, 64'd10, 1'b0);
        rd("idle_instret", CSR_INSTRET, 64'd0, 1'b0);
        check("idle_busy", 64'(csrBusy_o), 64'd0);

        capture(CSR_FCSR, 64'hA5);
        check("fcsr_busy1", 64'(csrBusy_o), 64'd1);
        rd("fcsr_nofwd", CSR_FCSR, 64'd0, 1'b0);
        cyc();
        check("fcsr_busy2", 64'(csrBusy_o), 64'd1);
        commitCsr_i = 1'b1;
        cyc();
        commitCsr_i = 1'b0;
        check("fcsr_busy_clr", 64'(csrBusy_o), 64'd0);
        check("fcsr_frm_o", 64'(frm_o), 64'd5);
        rd("fcsr_fflags", CSR_FFLAGS, 64'h05, 1'b0);
        rd("fcsr_read", CSR_FCSR, 64'hA5, 1'b0);

        capture(CSR_FRM, 64'd3);
        recoverFlag_i  = 1'b1;
        exeCsrWrEn_i   = 1'b1;
        exeCsrWrAddr_i = CSR_FRM;
        exeCsrWrData_i = 64'd1;
        cyc();
        recoverFlag_i = 1'b0;
        exeCsrWrEn_i  = 1'b0;
        check("rec_busy", 64'(csrBusy_o), 64'd0);
        check("rec_frm_o", 64'(frm_o), 64'd5);
        rd("rec_frm", CSR_FRM, 64'd5, 1'b0);

        capture(CSR_FFLAGS, 64'd0);
        commitCsr_i   = 1'b1;
        recoverFlag_i = 1'b1;
        cyc();
        commitCsr_i   = 1'b0;
        recoverFlag_i = 1'b0;
        check("cmrec_busy", 64'(csrBusy_o), 64'd0);
        rd("cmrec_fflags", CSR_FFLAGS, 64'd0, 1'b0);

        commitCnt_i    = 3'd4;
        fpFlagsValid_i = 1'b1;
        fpFlags_i      = 5'h01;
        cyc();
        fpFlags_i = 5'h10;
        cyc();
        fpFlagsValid_i = 1'b0;
        fpFlags_i      = 5'h00;
        cyc();
        commitCnt_i = 3'd0;
        rd("acc_instret", CSR_INSTRET, 64'd12, 1'b0);
        rd("acc_instreth", CSR_INSTRETH, 64'd12, 1'b0);
        rd("acc_fflags", CSR_FFLAGS, 64'h11, 1'b0);

        capture(CSR_FFLAGS, 64'h02);
        commitCsr_i    = 1'b1;
        fpFlagsValid_i = 1'b1;
        fpFlags_i      = 5'h04;
        cyc();
        commitCsr_i    = 1'b0;
        fpFlagsValid_i = 1'b0;
        fpFlags_i      = 5'h00;
        rd("wrwin_fflags", CSR_FFLAGS, 64'h02, 1'b0);

        force dut.u_instret.count = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.u_instret.count;
        commitCnt_i = 3'd3;
        cyc();
        commitCnt_i = 3'd0;
        rd("wrap_instret", CSR_INSTRET, 64'd1, 1'b0);

        wr_commit(CSR_CYCLE, 64'd0);
        rd("ro_cycle", CSR_TIME, cyc_m, 1'b0);
        rd("ro_cycleh", CSR_CYCLEH, cyc_m, 1'b0);
        wr_commit(12'h7FF, 64'hFF);
        rd("unmap_fcsr", CSR_FCSR, 64'hA2, 1'b0);
        rd("unmap_rd", 12'h123, 64'd0, 1'b1);

        wr_commit(CSR_SCRATCH, 64'hDEAD_BEEF);
`ifdef CSR_SCRATCH_EN
        rd("scratch", CSR_SCRATCH, 64'hDEAD_BEEF, 1'b0);
`else
        rd("scratch", CSR_SCRATCH, 64'd0, 1'b1);
`endif
        rd("scratch_fcsr", CSR_FCSR, 64'hA2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
